// File: rtl/hidden_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hidden_layer_sequencer_if
// Purpose  : Control/datapath bundle between the hidden-layer sequencer and
//            the layer FSM, input buffer, weight ROM and accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface hidden_layer_sequencer_if #(
  parameter int N_INPUTS  = 32,
  parameter int N_NEURONS = 16,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 10,
  parameter int ACC_W     = 24
);
  localparam int XW = $clog2(N_INPUTS);
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [XW-1:0]            x_addr;
  logic [ADDR_W-1:0]        w_addr;
  logic                     acc_clr;
  logic                     acc_en;
  logic signed [ACC_W-1:0]  acc_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [NW-1:0]            out_idx;

  modport master (
    input  start, acc_in, out_ready,
    output busy, done, x_addr, w_addr, acc_clr, acc_en,
           out_valid, out_data, out_idx
  );

  modport slave (
    output start, acc_in, out_ready,
    input  busy, done, x_addr, w_addr, acc_clr, acc_en,
           out_valid, out_data, out_idx
  );
endinterface
`default_nettype wire

// File: rtl/hidden_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hidden_layer_sequencer
// Purpose  : Walks every neuron of the hidden layer through clear, address
//            streaming, accumulate and scaled/saturated hand-off.
//            Optional ReLU on the output: define HL_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hidden_layer_sequencer #(
  parameter int N_INPUTS  = 32,
  parameter int N_NEURONS = 16,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 10,
  parameter int ACC_W     = 24,
  parameter int SHIFT     = 4
) (
  input  logic                     Clock,
  input  logic                     Clear,
  hidden_layer_sequencer_if.master bus
);

  localparam int XW = $clog2(N_INPUTS);
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] c_sat_min = ~c_sat_max;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    DRAIN1 = 3'd3,
    DRAIN2 = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [NW-1:0]            r_n;
  logic                     w_last_k;
  logic                     w_last_n;
  logic                     w_hs;
  logic [ADDR_W-1:0]        w_base;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [DATA_W-1:0] w_sat;
  logic signed [DATA_W-1:0] w_act;

  assign w_last_k = (bus.x_addr == XW'(N_INPUTS - 1));
  assign w_last_n = (r_n == NW'(N_NEURONS - 1));
  assign w_hs     = (r_state == OUT) && bus.out_ready;
  assign w_base   = ADDR_W'(r_n) * ADDR_W'(N_INPUTS);

  assign w_shift  = bus.acc_in >>> SHIFT;

  always_comb begin
    w_sat = w_shift[DATA_W-1:0];
    if (w_shift > c_sat_max) begin
      w_sat = c_sat_max[DATA_W-1:0];
    end else if (w_shift < c_sat_min) begin
      w_sat = c_sat_min[DATA_W-1:0];
    end
  end

`ifdef HL_RELU_EN
  assign w_act = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign w_act = w_sat;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = CLR;
      CLR:     w_next = RUN;
      RUN:     if (w_last_k) w_next = DRAIN1;
      DRAIN1:  w_next = DRAIN2;
      DRAIN2:  w_next = OUT;
      OUT:     if (bus.out_ready) w_next = w_last_n ? IDLE : CLR;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Control strobes are registered from the next state so they line up with it.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.acc_clr   <= 1'b0;
      bus.acc_en    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.x_addr    <= '0;
      bus.w_addr    <= '0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      r_n           <= '0;
    end else begin
      bus.busy      <= (w_next != IDLE);
      bus.done      <= w_hs && w_last_n;
      bus.acc_clr   <= (w_next == CLR);
      bus.acc_en    <= (r_state == RUN);
      bus.out_valid <= (w_next == OUT);

      if ((r_state == IDLE) && bus.start) begin
        bus.x_addr <= '0;
        bus.w_addr <= '0;
        r_n        <= '0;
      end else if (r_state == CLR) begin
        bus.x_addr <= '0;
        bus.w_addr <= w_base;
      end else if ((r_state == RUN) && !w_last_k) begin
        bus.x_addr <= bus.x_addr + XW'(1);
        bus.w_addr <= bus.w_addr + ADDR_W'(1);
      end

      // The last product lands in DRAIN1, so acc_in is final during DRAIN2.
      if (r_state == DRAIN2) begin
        bus.out_data <= w_act;
        bus.out_idx  <= r_n;
      end

      if (w_hs && !w_last_n) begin
        r_n <= r_n + NW'(1);
      end
    end
  end

endmodule
`default_nettype wire
